// File: rtl/l1_mem_arbiter_if.sv
// l1_mem_arbiter_if: bundle between both L1 controllers, the arbiter
// and the main-memory block port.
interface l1_mem_arbiter_if #(
  parameter int BLOCK_ADDR_W = 16,
  parameter int BLOCK_BITS   = 128
);
  logic                    icRen;
  logic [BLOCK_ADDR_W-1:0] icBlockAddr;
  logic                    icReadReady;
  logic [BLOCK_BITS-1:0]   icDout;
  logic                    dcRen;
  logic                    dcWen;
  logic [BLOCK_ADDR_W-1:0] dcBlockAddr;
  logic [BLOCK_BITS-1:0]   dcDin;
  logic                    dcReadReady;
  logic                    dcWriteDone;
  logic [BLOCK_BITS-1:0]   dcDout;
  logic                    memRen;
  logic                    memWen;
  logic [BLOCK_ADDR_W-1:0] memBlockAddr;
  logic [BLOCK_BITS-1:0]   memDin;
  logic                    memReadReady;
  logic                    memWriteDone;
  logic [BLOCK_BITS-1:0]   memDout;
  logic                    busy;
  logic                    grantD;

  modport slave (
    input  icRen, icBlockAddr,
    input  dcRen, dcWen, dcBlockAddr, dcDin,
    input  memReadReady, memWriteDone, memDout,
    output icReadReady, icDout,
    output dcReadReady, dcWriteDone, dcDout,
    output memRen, memWen, memBlockAddr, memDin,
    output busy, grantD
  );

  modport master (
    output icRen, icBlockAddr,
    output dcRen, dcWen, dcBlockAddr, dcDin,
    output memReadReady, memWriteDone, memDout,
    input  icReadReady, icDout,
    input  dcReadReady, dcWriteDone, dcDout,
    input  memRen, memWen, memBlockAddr, memDin,
    input  busy, grantD
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares the memory block port between I-cache refills
// and D-cache writeback/refill, round-robin with atomic wb+refill pairs.
module l1_mem_arbiter #(
  parameter int BLOCK_ADDR_W = 16,
  parameter int BLOCK_BITS   = 128
) (
  input  logic            clock,
  input  logic            reset,
  l1_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    WAIT_CLR
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   lock_d_q, lock_d_d;

  logic i_req;
  logic d_req;
  logic own_i;
  logic own_d;
  logic drain;

  logic [BLOCK_ADDR_W-1:0] addr_mux;
  logic [BLOCK_BITS-1:0]   din_mux;

  assign i_req = bus.icRen;
  assign d_req = bus.dcRen | bus.dcWen;
  assign own_i = (state_q == GNT_I);
  assign own_d = (state_q == GNT_D);
  assign drain = (state_q == WAIT_CLR);

  // State, round-robin pointer and wb->refill lock registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      lock_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_d_q     <= lock_d_d;
    end
  end

  // Arbitration, completion/abort detection and done-drain
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_d_d     = lock_d_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_grant_q)) begin
          state_d      = GNT_I;
          last_grant_d = 1'b0;
        end else if (d_req) begin
          state_d      = GNT_D;
          last_grant_d = 1'b1;
        end
      end
      GNT_I: begin
        if (!i_req || bus.memReadReady) begin
          state_d  = WAIT_CLR;
          lock_d_d = 1'b0;
        end
      end
      GNT_D: begin
        if (!d_req) begin
          state_d  = WAIT_CLR;
          lock_d_d = 1'b0;
        end else if (bus.dcWen) begin
          if (bus.memWriteDone) begin
            state_d  = WAIT_CLR;
            lock_d_d = bus.dcRen;
          end
        end else if (bus.memReadReady) begin
          state_d  = WAIT_CLR;
          lock_d_d = 1'b0;
        end
      end
      WAIT_CLR: begin
        if (!bus.memReadReady && !bus.memWriteDone) begin
          state_d  = lock_d_q ? GNT_D : IDLE;
          lock_d_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner mux towards memory; writeback wins over refill inside D
  always_comb begin
    addr_mux   = '0;
    din_mux    = '0;
    bus.memRen = 1'b0;
    bus.memWen = 1'b0;
    if (own_i) begin
      bus.memRen = bus.icRen;
      addr_mux   = bus.icBlockAddr;
    end else if (own_d) begin
      addr_mux   = bus.dcBlockAddr;
      bus.memWen = bus.dcWen;
      bus.memRen = bus.dcRen & ~bus.dcWen;
      if (bus.dcWen) begin
        din_mux = bus.dcDin;
      end
    end
  end

  assign bus.memBlockAddr = addr_mux;
  assign bus.memDin       = din_mux;

  assign bus.icDout      = bus.memDout;
  assign bus.dcDout      = bus.memDout;
  assign bus.icReadReady = bus.memReadReady & own_i;
  assign bus.dcReadReady = bus.memReadReady & own_d & ~bus.dcWen;
  assign bus.dcWriteDone = bus.memWriteDone & own_d & bus.dcWen;

  assign bus.busy   = (state_q != IDLE);
  assign bus.grantD = own_d | (drain & lock_d_q);
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: directed scenarios plus randomized traffic
// checked against an owner-level reference model.
module tb_l1_mem_arbiter;
  localparam int AW = 16;
  localparam int BW = 128;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  l1_mem_arbiter_if #(.BLOCK_ADDR_W(AW), .BLOCK_BITS(BW)) bus ();

  l1_mem_arbiter #(.BLOCK_ADDR_W(AW), .BLOCK_BITS(BW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // {memRen, memWen, icReadReady, dcReadReady, dcWriteDone, busy, grantD}
  wire [6:0] ctl = {bus.memRen, bus.memWen, bus.icReadReady,
                    bus.dcReadReady, bus.dcWriteDone, bus.busy, bus.grantD};

  function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.icRen        = 1'b0;
    bus.icBlockAddr  = '0;
    bus.dcRen        = 1'b0;
    bus.dcWen        = 1'b0;
    bus.dcBlockAddr  = '0;
    bus.dcDin        = '0;
    bus.memReadReady = 1'b0;
    bus.memWriteDone = 1'b0;
    bus.memDout      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.icRen   = 1'b1;
    bus.dcWen   = 1'b1;
    bus.dcDin   = {4{32'hDEADBEEF}};
    bus.memDout = {4{32'h12345678}};
    step();
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b0);
    end
    total++;
    if (bus.memBlockAddr !== 16'h0 || bus.memDin !== '0) begin
      bad++; $display("FAIL reset_bus addr=%h din=%h want 0", bus.memBlockAddr, bus.memDin);
    end
    total++;
    if (bus.icDout !== {4{32'h12345678}} || bus.dcDout !== {4{32'h12345678}}) begin
      bad++; $display("FAIL reset_dout ic=%h dc=%h", bus.icDout, bus.dcDout);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_i_refill();
    do_reset();
    bus.icRen       = 1'b1;
    bus.icBlockAddr = 16'h0010;
    #1;
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL i_latency got=%b want=%b", ctl, 7'b0);
    end
    step();
    total++;
    if (ctl !== 7'b1000010 || bus.memBlockAddr !== 16'h0010) begin
      bad++; $display("FAIL i_grant ctl=%b addr=%h want 1000010/0010", ctl, bus.memBlockAddr);
    end
    bus.memReadReady = 1'b1;
    bus.memDout      = {8'hAA, 120'h0};
    #1;
    total++;
    if (ctl !== 7'b1010010 || bus.icDout !== {8'hAA, 120'h0}) begin
      bad++; $display("FAIL i_ready ctl=%b dout=%h want 1010010", ctl, bus.icDout);
    end
    step();
    total++;
    if (ctl !== 7'b0000010) begin
      bad++; $display("FAIL i_waitclr got=%b want=%b", ctl, 7'b0000010);
    end
    bus.icRen        = 1'b0;
    bus.memReadReady = 1'b0;
    step();
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL i_idle got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_tie_alternation();
    do_reset();
    bus.icRen       = 1'b1;
    bus.icBlockAddr = 16'h0021;
    bus.dcRen       = 1'b1;
    bus.dcBlockAddr = 16'h0042;
    step();
    total++;
    if (ctl !== 7'b1000011 || bus.memBlockAddr !== 16'h0042) begin
      bad++; $display("FAIL tie1_d ctl=%b addr=%h want 1000011/0042", ctl, bus.memBlockAddr);
    end
    bus.memReadReady = 1'b1;
    #1;
    total++;
    if (ctl !== 7'b1001011) begin
      bad++; $display("FAIL tie1_drdy got=%b want=%b", ctl, 7'b1001011);
    end
    step();
    bus.dcRen        = 1'b0;
    bus.memReadReady = 1'b0;
    step();
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL tie1_idle got=%b want=%b", ctl, 7'b0);
    end
    step();
    total++;
    if (ctl !== 7'b1000010 || bus.memBlockAddr !== 16'h0021) begin
      bad++; $display("FAIL tie1_i ctl=%b addr=%h want 1000010/0021", ctl, bus.memBlockAddr);
    end
    bus.memReadReady = 1'b1;
    step();
    bus.icRen        = 1'b0;
    bus.memReadReady = 1'b0;
    step();
    bus.icRen = 1'b1;
    bus.dcRen = 1'b1;
    step();
    total++;
    if (ctl !== 7'b1000011) begin
      bad++; $display("FAIL tie2_d got=%b want=%b", ctl, 7'b1000011);
    end
    do_reset();
  endtask

  task automatic test_wb_lock();
    do_reset();
    bus.dcWen       = 1'b1;
    bus.dcRen       = 1'b1;
    bus.dcBlockAddr = 16'h0003;
    bus.dcDin       = {8'hFF, 120'h0};
    step();
    total++;
    if (ctl !== 7'b0100011 || bus.memDin !== {8'hFF, 120'h0} || bus.memBlockAddr !== 16'h0003) begin
      bad++; $display("FAIL wb_grant ctl=%b din=%h addr=%h", ctl, bus.memDin, bus.memBlockAddr);
    end
    bus.icRen        = 1'b1;
    bus.icBlockAddr  = 16'h0055;
    bus.memWriteDone = 1'b1;
    #1;
    total++;
    if (ctl !== 7'b0100111) begin
      bad++; $display("FAIL wb_done got=%b want=%b", ctl, 7'b0100111);
    end
    step();
    total++;
    if (ctl !== 7'b0000011) begin
      bad++; $display("FAIL wb_locked got=%b want=%b", ctl, 7'b0000011);
    end
    bus.dcWen        = 1'b0;
    bus.memWriteDone = 1'b0;
    step();
    total++;
    if (ctl !== 7'b1000011 || bus.memBlockAddr !== 16'h0003 || bus.memDin !== '0) begin
      bad++; $display("FAIL wb_refill ctl=%b addr=%h din=%h", ctl, bus.memBlockAddr, bus.memDin);
    end
    bus.memReadReady = 1'b1;
    #1;
    total++;
    if (ctl !== 7'b1001011) begin
      bad++; $display("FAIL wb_rdy got=%b want=%b", ctl, 7'b1001011);
    end
    step();
    bus.dcRen        = 1'b0;
    bus.memReadReady = 1'b0;
    #1;
    total++;
    if (ctl !== 7'b0000010) begin
      bad++; $display("FAIL wb_unlock got=%b want=%b", ctl, 7'b0000010);
    end
    step();
    step();
    total++;
    if (ctl !== 7'b1000010 || bus.memBlockAddr !== 16'h0055) begin
      bad++; $display("FAIL wb_then_i ctl=%b addr=%h want 1000010/0055", ctl, bus.memBlockAddr);
    end
    do_reset();
  endtask

  task automatic test_wait_hold();
    do_reset();
    bus.icRen = 1'b1;
    step();
    bus.memReadReady = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (ctl !== 7'b0000010) begin
        bad++; $display("FAIL hold_%0d got=%b want=%b", i, ctl, 7'b0000010);
      end
      step();
    end
    bus.icRen        = 1'b0;
    bus.memReadReady = 1'b0;
    step();
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL hold_release got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.dcWen = 1'b1;
    bus.dcRen = 1'b1;
    step();
    total++;
    if (ctl !== 7'b0100011) begin
      bad++; $display("FAIL rmid_pre got=%b want=%b", ctl, 7'b0100011);
    end
    reset = 1'b1;
    step();
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL rmid_post got=%b want=%b", ctl, 7'b0);
    end
    reset     = 1'b0;
    bus.dcWen = 1'b0;
    bus.icRen = 1'b1;
    step();
    total++;
    if (ctl !== 7'b1000011) begin
      bad++; $display("FAIL rmid_tie got=%b want=%b", ctl, 7'b1000011);
    end
    do_reset();
  endtask

  task automatic test_abort();
    do_reset();
    bus.icRen = 1'b1;
    step();
    bus.dcRen = 1'b1;
    bus.icRen = 1'b0;
    #1;
    total++;
    if (ctl !== 7'b0000010) begin
      bad++; $display("FAIL abort_gnt got=%b want=%b", ctl, 7'b0000010);
    end
    step();
    total++;
    if (ctl !== 7'b0000010) begin
      bad++; $display("FAIL abort_wait got=%b want=%b", ctl, 7'b0000010);
    end
    step();
    total++;
    if (ctl !== 7'b0) begin
      bad++; $display("FAIL abort_idle got=%b want=%b", ctl, 7'b0);
    end
    step();
    total++;
    if (ctl !== 7'b1000011) begin
      bad++; $display("FAIL abort_d got=%b want=%b", ctl, 7'b1000011);
    end
    do_reset();
  endtask

  task automatic test_random();
    int       owner;
    bit       cool;
    bit       lock;
    bit       turn_d;
    int       lat;
    int       cnt;
    bit       saw_i;
    bit       saw_dr;
    bit       saw_dw;
    bit       done;
    bit       ir;
    bit       dr;
    logic [6:0]    e_ctl;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_din;
    do_reset();
    owner  = 0;
    cool   = 1'b0;
    lock   = 1'b0;
    turn_d = 1'b1;
    lat    = 0;
    cnt    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      e_ctl[6] = (owner == 1) ? bus.icRen :
                 (owner == 2) ? (bus.dcRen & ~bus.dcWen) : 1'b0;
      e_ctl[5] = (owner == 2) && bus.dcWen;
      e_ctl[4] = bus.memReadReady && owner == 1;
      e_ctl[3] = bus.memReadReady && owner == 2 && !bus.dcWen;
      e_ctl[2] = bus.memWriteDone && owner == 2 && bus.dcWen;
      e_ctl[1] = (owner != 0) || cool;
      e_ctl[0] = (owner == 2) || (cool && lock);
      e_addr   = (owner == 1) ? bus.icBlockAddr :
                 (owner == 2) ? bus.dcBlockAddr : '0;
      e_din    = e_ctl[5] ? bus.dcDin : '0;
      total++;
      if (ctl !== e_ctl) begin
        bad++; $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", cyc, ctl, e_ctl);
      end
      total++;
      if (bus.memBlockAddr !== e_addr || bus.memDin !== e_din) begin
        bad++; $display("FAIL rnd_bus cyc=%0d addr=%h/%h din=%h/%h", cyc,
                        bus.memBlockAddr, e_addr, bus.memDin, e_din);
      end
      total++;
      if (bus.icDout !== bus.memDout || bus.dcDout !== bus.memDout) begin
        bad++; $display("FAIL rnd_dout cyc=%0d ic=%h dc=%h", cyc, bus.icDout, bus.dcDout);
      end
      saw_i  = bus.icReadReady;
      saw_dr = bus.dcReadReady;
      saw_dw = bus.dcWriteDone;
      if (saw_i) begin
        total++;
        if (bus.icDout !== blk(bus.icBlockAddr)) begin
          bad++; $display("FAIL rnd_idata cyc=%0d got=%h want=%h", cyc, bus.icDout, blk(bus.icBlockAddr));
        end
      end
      if (saw_dr) begin
        total++;
        if (bus.dcDout !== blk(bus.dcBlockAddr)) begin
          bad++; $display("FAIL rnd_ddata cyc=%0d got=%h want=%h", cyc, bus.dcDout, blk(bus.dcBlockAddr));
        end
      end
      ir = bus.icRen;
      dr = bus.dcRen | bus.dcWen;
      if (reset) begin
        owner  = 0;
        cool   = 1'b0;
        lock   = 1'b0;
        turn_d = 1'b1;
      end else if (cool) begin
        if (!bus.memReadReady && !bus.memWriteDone) begin
          cool = 1'b0;
          if (lock) begin
            owner = 2;
            lock  = 1'b0;
          end
        end
      end else if (owner == 0) begin
        if (ir && dr) begin
          owner  = turn_d ? 2 : 1;
          turn_d = ~turn_d;
        end else if (ir) begin
          owner  = 1;
          turn_d = 1'b1;
        end else if (dr) begin
          owner  = 2;
          turn_d = 1'b0;
        end
      end else if (owner == 1) begin
        if (!ir || bus.memReadReady) begin
          owner = 0;
          cool  = 1'b1;
        end
      end else begin
        done = bus.dcWen ? bus.memWriteDone : bus.memReadReady;
        if (!dr) begin
          owner = 0;
          cool  = 1'b1;
          lock  = 1'b0;
        end else if (done) begin
          lock  = bus.dcWen && bus.dcRen;
          owner = 0;
          cool  = 1'b1;
        end
      end
      @(posedge clock);
      #1;
      reset = ($urandom_range(0, 199) == 0);
      if (saw_i) begin
        bus.icRen = 1'b0;
      end else if (!bus.icRen && $urandom_range(0, 3) == 0) begin
        bus.icRen       = 1'b1;
        bus.icBlockAddr = AW'($urandom);
      end
      if (saw_dw) begin
        bus.dcWen = 1'b0;
      end
      if (saw_dr) begin
        bus.dcRen = 1'b0;
      end else if (!bus.dcRen && !bus.dcWen && $urandom_range(0, 3) == 0) begin
        bus.dcWen       = $urandom_range(0, 1) == 1;
        bus.dcRen       = 1'b1;
        bus.dcBlockAddr = AW'($urandom);
        bus.dcDin       = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      if (bus.memRen || bus.memWen) begin
        if (cnt >= lat) begin
          bus.memReadReady = bus.memRen;
          bus.memWriteDone = bus.memWen;
          bus.memDout      = blk(bus.memBlockAddr);
        end else begin
          cnt++;
        end
      end else begin
        bus.memReadReady = 1'b0;
        bus.memWriteDone = 1'b0;
        bus.memDout      = {$urandom, $urandom, $urandom, $urandom};
        cnt              = 0;
        lat              = $urandom_range(0, 3);
      end
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_i_refill();
    test_tie_alternation();
    test_wb_lock();
    test_wait_hold();
    test_reset_mid();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
